// File: rtl/alarm_controller.sv
// Multi-channel alarm controller: NumAlarms independently programmable alarms
// that ring, snooze, dismiss and time out against the timekeeping counter.
module alarm_controller #(
    parameter int NumAlarms     = 4,
    parameter int SnoozeMinutes = 5,
    parameter int RingSeconds   = 60,
    localparam int IndexWidth   = (NumAlarms > 1) ? $clog2(NumAlarms) : 1
) (
    input  logic                  Clk,
    input  logic                  Reset,
    input  logic                  ClockTick,
    input  logic [7:0]            ClockSeconds,
    input  logic [7:0]            ClockMinutes,
    input  logic [7:0]            ClockHours,
    input  logic                  SetEn,
    input  logic [IndexWidth-1:0] SetIndex,
    input  logic [7:0]            SetSeconds,
    input  logic [7:0]            SetMinutes,
    input  logic [7:0]            SetHours,
    input  logic                  SetArm,
    input  logic                  Snooze,
    input  logic                  Dismiss,
    output logic                  Alarm,
    output logic [NumAlarms-1:0]  RingingMask,
    output logic [NumAlarms-1:0]  SnoozedMask,
    output logic [IndexWidth-1:0] ActiveIndex
);

    typedef enum logic [1:0] {
        Idle    = 2'd0,
        Armed   = 2'd1,
        Ringing = 2'd2,
        Snoozed = 2'd3
    } AlarmState;

    AlarmState state     [NumAlarms];
    AlarmState stateNext [NumAlarms];

    logic [7:0] almSec      [NumAlarms];
    logic [7:0] almMin      [NumAlarms];
    logic [7:0] almHour     [NumAlarms];
    logic [7:0] almSecNext  [NumAlarms];
    logic [7:0] almMinNext  [NumAlarms];
    logic [7:0] almHourNext [NumAlarms];

    logic [7:0] snzSec      [NumAlarms];
    logic [7:0] snzMin      [NumAlarms];
    logic [7:0] snzHour     [NumAlarms];
    logic [7:0] snzSecNext  [NumAlarms];
    logic [7:0] snzMinNext  [NumAlarms];
    logic [7:0] snzHourNext [NumAlarms];

    logic [7:0] ringCount     [NumAlarms];
    logic [7:0] ringCountNext [NumAlarms];

    logic [NumAlarms-1:0]  ringingNext;
    logic [NumAlarms-1:0]  snoozedNext;
    logic [IndexWidth-1:0] activeNext;

    logic [7:0] targetMin;
    logic [7:0] targetHour;
    logic [7:0] minuteSum;
    logic [7:0] hourSum;

    // Snooze target: current clock time plus SnoozeMinutes, carrying into hours
    // and wrapping the hour at 24; seconds are carried over unchanged.
    always_comb begin
        minuteSum = ClockMinutes + 8'(SnoozeMinutes);
        hourSum   = ClockHours;
        if (minuteSum >= 8'd60) begin
            minuteSum = minuteSum - 8'd60;
            hourSum   = ClockHours + 8'd1;
        end
        if (hourSum >= 8'd24) begin
            hourSum = hourSum - 8'd24;
        end
        targetMin  = minuteSum;
        targetHour = hourSum;
    end

    // State register: channel state, stored times and registered outputs.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            for (int i = 0; i < NumAlarms; i++) begin
                state[i]     <= Idle;
                almSec[i]    <= 8'd0;
                almMin[i]    <= 8'd0;
                almHour[i]   <= 8'd0;
                snzSec[i]    <= 8'd0;
                snzMin[i]    <= 8'd0;
                snzHour[i]   <= 8'd0;
                ringCount[i] <= 8'd0;
            end
            RingingMask <= '0;
            SnoozedMask <= '0;
            ActiveIndex <= '0;
            Alarm       <= 1'b0;
        end else begin
            for (int i = 0; i < NumAlarms; i++) begin
                state[i]     <= stateNext[i];
                almSec[i]    <= almSecNext[i];
                almMin[i]    <= almMinNext[i];
                almHour[i]   <= almHourNext[i];
                snzSec[i]    <= snzSecNext[i];
                snzMin[i]    <= snzMinNext[i];
                snzHour[i]   <= snzHourNext[i];
                ringCount[i] <= ringCountNext[i];
            end
            RingingMask <= ringingNext;
            SnoozedMask <= snoozedNext;
            ActiveIndex <= activeNext;
            Alarm       <= |ringingNext;
        end
    end

    // Next-state logic per channel, priority SetEn > Dismiss > Snooze > tick.
    // A tick that times out the ring counter returns the channel to Armed so it
    // rings again the next day.
    always_comb begin
        for (int i = 0; i < NumAlarms; i++) begin
            stateNext[i]     = state[i];
            almSecNext[i]    = almSec[i];
            almMinNext[i]    = almMin[i];
            almHourNext[i]   = almHour[i];
            snzSecNext[i]    = snzSec[i];
            snzMinNext[i]    = snzMin[i];
            snzHourNext[i]   = snzHour[i];
            ringCountNext[i] = ringCount[i];

            if (SetEn && (int'(SetIndex) == i)) begin
                almSecNext[i]    = SetSeconds;
                almMinNext[i]    = SetMinutes;
                almHourNext[i]   = SetHours;
                snzSecNext[i]    = 8'd0;
                snzMinNext[i]    = 8'd0;
                snzHourNext[i]   = 8'd0;
                ringCountNext[i] = 8'd0;
                stateNext[i]     = SetArm ? Armed : Idle;
            end else if (Dismiss && (state[i] == Ringing || state[i] == Snoozed)) begin
                stateNext[i]     = Armed;
                ringCountNext[i] = 8'd0;
            end else if (Snooze && state[i] == Ringing) begin
                stateNext[i]   = Snoozed;
                snzSecNext[i]  = ClockSeconds;
                snzMinNext[i]  = targetMin;
                snzHourNext[i] = targetHour;
            end else if (ClockTick) begin
                case (state[i])
                    Armed: begin
                        if (ClockSeconds == almSec[i] && ClockMinutes == almMin[i] &&
                            ClockHours == almHour[i]) begin
                            stateNext[i]     = Ringing;
                            ringCountNext[i] = 8'(RingSeconds);
                        end
                    end
                    Ringing: begin
                        if (ringCount[i] <= 8'd1) begin
                            stateNext[i]     = Armed;
                            ringCountNext[i] = 8'd0;
                        end else begin
                            ringCountNext[i] = ringCount[i] - 8'd1;
                        end
                    end
                    Snoozed: begin
                        if (ClockSeconds == snzSec[i] && ClockMinutes == snzMin[i] &&
                            ClockHours == snzHour[i]) begin
                            stateNext[i]     = Ringing;
                            ringCountNext[i] = 8'(RingSeconds);
                        end
                    end
                    default: begin
                        stateNext[i] = state[i];
                    end
                endcase
            end
        end
    end

    // Output decode from the next state so the masks are registered alongside it.
    always_comb begin
        ringingNext = '0;
        snoozedNext = '0;
        activeNext  = '0;
        for (int i = NumAlarms - 1; i >= 0; i--) begin
            ringingNext[i] = (stateNext[i] == Ringing);
            snoozedNext[i] = (stateNext[i] == Snoozed);
            if (stateNext[i] == Ringing) begin
                activeNext = IndexWidth'(i);
            end
        end
    end

endmodule
